// File: rtl/tape_player_pkg.sv
// Shared types and defaults for the tape player.
//   state_t      : sequencer states
//   cell_t       : value carried by one bit cell
//   half_ticks() : half-period length, in ce ticks, for a cell value
package tape_player_pkg;

  localparam int unsigned DEF_AW   = 14;
  localparam int unsigned DEF_ZH   = 4;
  localparam int unsigned DEF_OH   = 8;
  localparam int unsigned DEF_LEAD = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_SYNC,
    S_FETCH,
    S_LOAD,
    S_BITH,
    S_BITL,
    S_FIN
  } state_t;

  typedef enum logic {
    CELL_ZERO = 1'b0,
    CELL_ONE  = 1'b1
  } cell_t;

  function automatic int unsigned half_ticks(input logic b, input int unsigned zh,
                                             input int unsigned oh);
    return b ? oh : zh;
  endfunction

endpackage

// File: rtl/tape_player_cell.sv
// One pulse-width bit cell: ear high for H ce ticks, then low for H ticks.
//   clock, reset : clock and async active-high reset
//   ce           : timing tick
//   go           : start a new cell (ear rises on this edge, ticks count from next ce)
//   abort        : drop the cell immediately
//   bit_val      : cell value, sampled with go
//   ear          : registered tape level
//   half_done_c  : last tick of the high half is on this edge
//   cell_done_c  : last tick of the low half is on this edge
module tape_cell
  import tape_player_pkg::*;
#(
  parameter int unsigned ZH = DEF_ZH,
  parameter int unsigned OH = DEF_OH
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic go,
  input  logic abort,
  input  logic bit_val,
  output logic ear,
  output logic half_done_c,
  output logic cell_done_c
);

  localparam int unsigned HMAX = (OH > ZH) ? OH : ZH;
  localparam int unsigned CW   = $clog2(HMAX + 1);

  logic          active_q, active_d;
  logic          low_q, low_d;
  cell_t         bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ear_q, ear_d;
  logic          last_tick;

  assign last_tick   = active_q & ce & (cnt_q == CW'(1));
  assign half_done_c = last_tick & ~low_q;
  assign cell_done_c = last_tick & low_q;
  assign ear         = ear_q;

  // A new go wins over the tick on the same edge, so the entry edge is never counted.
  always_comb begin
    active_d = active_q;
    low_d    = low_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    ear_d    = ear_q;
    if (abort) begin
      active_d = 1'b0;
      low_d    = 1'b0;
      cnt_d    = '0;
      ear_d    = 1'b0;
    end else if (go) begin
      active_d = 1'b1;
      low_d    = 1'b0;
      bit_d    = cell_t'(bit_val);
      cnt_d    = CW'(half_ticks(bit_val, ZH, OH));
      ear_d    = 1'b1;
    end else if (active_q && ce) begin
      if (cnt_q == CW'(1)) begin
        if (!low_q) begin
          low_d = 1'b1;
          cnt_d = CW'(half_ticks(bit_q, ZH, OH));
          ear_d = 1'b0;
        end else begin
          active_d = 1'b0;
          low_d    = 1'b0;
          cnt_d    = '0;
          ear_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      low_q    <= 1'b0;
      bit_q    <= CELL_ZERO;
      cnt_q    <= '0;
      ear_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      low_q    <= low_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      ear_q    <= ear_d;
    end
  end

endmodule

// File: rtl/tape_player.sv
// Walks a byte range of the tape ROM and emits it as a pulse-width EAR signal:
// LEAD '0' cells, one '1' sync cell, then each byte MSB first.
//   clock, reset : clock and async active-high reset
//   ce           : timing tick
//   play / stop  : start / abort strobes
//   start, len   : first ROM address and byte count, sampled on accepted play
//   romCe, romA  : ROM read enable and address; romDo returns the clock after
//   ear          : tape level
//   busy / done  : activity flag / completion pulse
module tape_player
  import tape_player_pkg::*;
#(
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned ZH   = DEF_ZH,
  parameter int unsigned OH   = DEF_OH,
  parameter int unsigned LEAD = DEF_LEAD
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          play,
  input  logic          stop,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] len,
  output logic          romCe,
  output logic [AW-1:0] romA,
  input  logic [7:0]    romDo,
  output logic          ear,
  output logic          busy,
  output logic          done
);

  localparam int unsigned LW = $clog2(LEAD + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          romce_q, romce_d;
  logic [AW-1:0] roma_q, roma_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          go;
  logic          go_bit;
  logic          half_done_c;
  logic          cell_done_c;

  tape_cell #(
    .ZH(ZH),
    .OH(OH)
  ) u_cell (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .go         (go),
    .abort      (stop),
    .bit_val    (go_bit),
    .ear        (ear),
    .half_done_c(half_done_c),
    .cell_done_c(cell_done_c)
  );

  // Sequencer: go is raised on the edge a cell state is (re)entered.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lead_d  = lead_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    go      = 1'b0;
    go_bit  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            addr_d  = start;
            rem_d   = len;
            lead_d  = LW'(LEAD);
            go      = 1'b1;
            state_d = S_LEADER;
          end
        end
        S_LEADER: begin
          if (cell_done_c) begin
            go = 1'b1;
            if (lead_q == LW'(1)) begin
              go_bit  = 1'b1;
              state_d = S_SYNC;
            end else begin
              lead_d = lead_q - LW'(1);
            end
          end
        end
        S_SYNC: begin
          if (cell_done_c) state_d = (rem_q != '0) ? S_FETCH : S_FIN;
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          shift_d = romDo;
          idx_d   = 3'd7;
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - AW'(1);
          go      = 1'b1;
          go_bit  = romDo[7];
          state_d = S_BITH;
        end
        S_BITH: begin
          if (half_done_c) state_d = S_BITL;
        end
        S_BITL: begin
          if (cell_done_c) begin
            if (idx_q == 3'd0) begin
              state_d = (rem_q != '0) ? S_FETCH : S_FIN;
            end else begin
              idx_d   = idx_q - 3'd1;
              go      = 1'b1;
              go_bit  = shift_q[idx_d];
              state_d = S_BITH;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state; romA holds between reads.
  always_comb begin
    romce_d = (state_d == S_FETCH);
    roma_d  = (state_d == S_FETCH) ? addr_q : roma_q;
    busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lead_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      romce_q <= 1'b0;
      roma_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lead_q  <= lead_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      romce_q <= romce_d;
      roma_q  <= roma_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign romCe = romce_q;
  assign romA  = roma_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tape_player.sv
// Scoreboard bench for tape_player: expected ear segments (level, ce ticks)
// and ROM addresses are queued when a play is issued and compared as observed.
module tb_tape_player;

  localparam int AW   = 14;
  localparam int ZH   = 4;
  localparam int OH   = 8;
  localparam int LEAD = 2;
  localparam int ROMN = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic          play  = 1'b0;
  logic          stop  = 1'b0;
  logic [AW-1:0] start = '0;
  logic [AW-1:0] len   = '0;
  logic          rom_ce;
  logic [AW-1:0] rom_a;
  logic [7:0]    rom_do = 8'h00;
  logic          ear, busy, done;

  logic [7:0] mem [ROMN];

  int seg_q[$];
  int addr_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int seg_seen = 0;
  bit flush    = 1'b0;
  bit in_seg   = 1'b0;
  bit cur_lvl  = 1'b0;
  int ticks    = 0;

  tape_player #(.AW(AW), .ZH(ZH), .OH(OH), .LEAD(LEAD)) dut (
    .clock(clock), .reset(reset), .ce(ce), .play(play), .stop(stop),
    .start(start), .len(len), .romCe(rom_ce), .romA(rom_a), .romDo(rom_do),
    .ear(ear), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // ROM: data valid the clock after an enabled read.
  always @(posedge clock) if (rom_ce) rom_do <= mem[rom_a];

  // ce: one-clock pulse every 4 clocks.
  initial begin
    int c = 0;
    forever begin
      @(posedge clock);
      #1;
      ce = (c == 3);
      c  = (c + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic close_seg();
    seg_seen++;
    if (seg_q.size() == 0) check("seg_extra", 32'(cur_lvl * 1000 + ticks), 32'hFFFF_FFFF);
    else check("seg", 32'(cur_lvl * 1000 + ticks), 32'(seg_q.pop_front()));
  endtask

  // Monitor: segments are bounded by ear edges, a ROM fetch or done.
  always @(negedge clock) begin
    if (reset || flush) begin
      in_seg = 1'b0;
      seg_q.delete();
      addr_q.delete();
      flush = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (rom_ce) begin
        if (addr_q.size() == 0) check("romce_spurious", 32'd1, 32'd0);
        else check("rom_addr", 32'(rom_a), 32'(addr_q.pop_front()));
      end
      if (rom_ce || done) begin
        if (in_seg) close_seg();
        in_seg = 1'b0;
      end else if (in_seg && (ear !== cur_lvl)) begin
        close_seg();
        cur_lvl = ear;
        ticks   = int'(ce);
      end else if (in_seg) begin
        ticks += int'(ce);
      end else if (ear === 1'b1) begin
        in_seg  = 1'b1;
        cur_lvl = 1'b1;
        ticks   = int'(ce);
      end
    end
  end

  task automatic push_cell(input int h);
    seg_q.push_back(1000 + h);
    seg_q.push_back(h);
  endtask

  task automatic push_play(input int st, input int n);
    for (int i = 0; i < LEAD; i++) push_cell(ZH);
    push_cell(OH);
    for (int b = 0; b < n; b++) begin
      int a;
      a = (st + b) % ROMN;
      addr_q.push_back(a);
      for (int k = 7; k >= 0; k--) push_cell(mem[a][k] ? OH : ZH);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_play(input int st, input int n);
    push_play(st, n);
    start = AW'(st);
    len   = AW'(n);
    play  = 1'b1;
    step();
    play  = 1'b0;
    check("busy_on_play", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 6000; i++) begin
      if (!busy) break;
      step();
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) step();
  endtask

  task automatic wait_segs(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (seg_seen >= target && ear === 1'b1) break;
      step();
    end
    check("wait_segs_timeout", 32'(seg_seen >= target), 32'd1);
  endtask

  task automatic end_checks(input string tag, input int d0, input int exp_done);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
    check({tag, "_segs_left"}, 32'(seg_q.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int base;
    for (int i = 0; i < ROMN; i++) mem[i] = 8'(i * 37 + 11);
    mem[16'h0010] = 8'hA5;
    mem[16'h3FFF] = 8'h3C;
    mem[16'h0000] = 8'hC1;

    repeat (3) step();
    check("rst_ear", 32'(ear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_romce", 32'(rom_ce), 32'd0);
    check("rst_roma", 32'(rom_a), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    // len=0: leader and sync only, no ROM read.
    d0 = done_cnt;
    do_play(0, 0);
    wait_idle("len0_idle");
    end_checks("len0", d0, 1);

    // one byte 0xA5 at 0x0010
    d0 = done_cnt;
    do_play(16'h0010, 1);
    wait_idle("a5_idle");
    end_checks("a5", d0, 1);

    // address wrap 0x3FFF -> 0x0000
    d0 = done_cnt;
    do_play(16'h3FFF, 2);
    wait_idle("wrap_idle");
    end_checks("wrap", d0, 1);

    // stop during the third data bit, then restart from a new start
    d0   = done_cnt;
    base = seg_seen;
    do_play(16'h0100, 3);
    wait_segs(base + 2 * LEAD + 2 + 4);
    stop  = 1'b1;
    flush = 1'b1;
    step();
    stop = 1'b0;
    check("stop_ear", 32'(ear), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_romce", 32'(rom_ce), 32'd0);
    repeat (20) step();
    check("stop_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    do_play(16'h0200, 1);
    wait_idle("restart_idle");
    end_checks("restart", d0, 1);

    // play while busy is ignored
    d0 = done_cnt;
    do_play(16'h0020, 2);
    repeat (40) step();
    start = AW'(16'h0030);
    len   = AW'(1);
    play  = 1'b1;
    step();
    play  = 1'b0;
    wait_idle("busyplay_idle");
    end_checks("busyplay", d0, 1);

    // asynchronous reset while a data bit is high
    base = seg_seen;
    do_play(16'h0010, 1);
    wait_segs(base + 2 * LEAD + 2);
    check("pre_rst_ear", 32'(ear), 32'd1);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    #1;
    check("arst_ear", 32'(ear), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_romce", 32'(rom_ce), 32'd0);
    step();
    check("arst2_ear", 32'(ear), 32'd0);
    check("arst2_busy", 32'(busy), 32'd0);
    check("arst2_done", 32'(done), 32'd0);
    check("arst2_romce", 32'(rom_ce), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tape_player.md
Name: tape_player

Overview:
- Downstream consumer of the synchronous tape-image ROM: walks a byte range of the ROM and serializes it into a Lynx-style pulse-width-encoded EAR signal.
- Feeds the CPU port's tape input, so images load without a physical cassette.
- Owns the ROM read-enable and address; the ROM returns data one clock after an enabled read.

Parameters:
- AW, 14, ROM address width (byte-addressed).
- ZH, 4, ce ticks per half-period of a '0' bit.
- OH, 8, ce ticks per half-period of a '1' bit.
- LEAD, 16, number of '0' bits in the leader before the sync bit.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  timing tick; one-clock pulse, period ≥ 3 clocks
- play  in  1  one-clock start strobe; ignored while busy
- stop  in  1  one-clock abort strobe
- start  in  AW  first ROM address, sampled on accepted play
- len  in  AW  byte count, sampled on accepted play; 0 means no data bytes
- romCe  out  1  ROM read enable
- romA  out  AW  ROM address
- romDo  in  8  ROM data, valid the clock after romCe=1
- ear  out  1  tape signal level
- busy  out  1  high from accepted play until done or stop
- done  out  1  one-clock pulse when the final half-period completes

Behaviour:
- Reset (async, any state): state IDLE; ear=0, busy=0, done=0, romCe=0, romA=0; counters and shift register cleared.
- All state changes occur on clock edges. Half-period timers decrement only on clock edges where ce=1.
- States: IDLE, LEADER, SYNC, FETCH, LOAD, BITH, BITL, FIN.
- IDLE
  - play=1: latch start into the address register and len into the remaining-count register.
  - Load leader count = LEAD, set busy=1, go to LEADER.
- Bit cell (shared by LEADER, SYNC and data bits)
  - ear=1 for H ticks, then ear=0 for H ticks; H=ZH for '0' and OH for '1'.
  - A cell's first high half starts on the clock the state is entered. Its ticks are counted from the next ce.
- LEADER: emits LEAD '0' cells, then goes to SYNC.
- SYNC: emits one '1' cell. Then goes to FETCH if remaining>0; otherwise goes to FIN.
- FETCH (1 clock): romCe=1, romA=address, go to LOAD.
- LOAD (1 clock):
  - Shift register ← romDo; bit index ← 7.
  - address ← address+1 (wraps modulo 2^AW); remaining ← remaining−1.
  - Go to BITH.
- Between-cell gap: FETCH and LOAD add exactly 2 clocks of ear=0 between cells; there is no ce-tick gap.
- BITH/BITL: output bits MSB first.
  - After bit 0's low half: go to FETCH if remaining>0; otherwise go to FIN.
- FIN (1 clock): done=1, busy=0, ear=0, go to IDLE.
- romCe=1 only in FETCH; romA holds its last value otherwise.
- stop=1 in any non-IDLE state:
  - Next clock: IDLE, ear=0, busy=0, romCe=0.
  - done is not pulsed.
  - stop has priority over play and over any transition on the same clock.
- play while busy: ignored; start and len are not re-sampled.
- play and stop on the same clock in IDLE: stop wins, stay IDLE.
- ce asserted during FETCH/LOAD: the tick is not counted.
- len=0: leader + sync only, then done; no ROM read occurs.

Decomposition:
- Shared package: state enumeration, bit-cell type ('0'/'1'), default ZH/OH/LEAD constants.
- One natural sub-module, tape_cell: given a bit value and a go strobe, generates the two half-periods on ce ticks, drives ear, and returns a cell-done strobe. It is reused by LEADER, SYNC and data bits.

Test Plan:
- Reset mid-play (during BITH, ear=1): assert reset → ear, busy, done, romCe all 0 immediately (asynchronous); the bench checks both before and after the next clock edge.
- len=0, LEAD=2, ZH=4, OH=8, ce every 4 clocks, play → ear pattern 4H/4L, 4H/4L, 8H/8L; done pulses once; romCe never 1.
- start=0x0010, len=1, ROM[0x10]=0xA5 → romCe=1 once with romA=0x0010; after sync, cells are 1,0,1,0,0,1,0,1 (OH/ZH half-widths); done follows.
- start=0x3FFF, len=2 (AW=14) → reads at 0x3FFF then 0x0000; 16 data cells emitted.
- stop during the third data bit of a 3-byte play → IDLE next clock, ear=0, busy=0, no done; a following play restarts from the new start with the leader.
- play pulsed again while busy with a different start → ignored; the original byte sequence and length are emitted unchanged.
